// File: rtl/shreg_pkg.sv
// Shared types and constants for the universal shift register and its burst controller.
package shreg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_FIN   = 2'b10
    } state_e;

    localparam logic DIR_R = 1'b0;
    localparam logic DIR_L = 1'b1;

endpackage

// File: rtl/shreg_burst_ctrl.sv
// Burst sequencer: counts down a clamped number of shifts, then pulses done from FIN.
module shreg_burst_ctrl
    import shreg_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [LEN_W-1:0] len,
    output logic             shift_en,
    output logic             shift_dir,
    output logic             idle,
    output logic             busy,
    output logic             done
);

    localparam logic [LEN_W-1:0] WIDTH_LEN = LEN_W'(WIDTH);

    state_e           state_q;
    state_e           state_d;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_d;
    logic             dir_d;

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dir_d   = shift_dir;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_BURST;
                        dir_d   = dir;
                        count_d = (len > WIDTH_LEN) ? WIDTH_LEN : len;
                    end
                end
            end
            ST_BURST: begin
                // Leaving at count 1 means the counter can never step below zero
                if (count_q <= LEN_W'(1)) begin
                    state_d = ST_FIN;
                    count_d = '0;
                end else begin
                    count_d = count_q - LEN_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // State register with status flags registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            shift_dir <= DIR_R;
            shift_en  <= 1'b0;
            idle      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shift_dir <= dir_d;
            shift_en  <= (state_d == ST_BURST);
            idle      <= (state_d == ST_IDLE);
            busy      <= (state_d == ST_BURST);
            done      <= (state_d == ST_FIN);
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift-right / shift-left / load, plus a timed burst engine.
module univ_shift_reg
    import shreg_pkg::*;
#(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0,
    parameter int unsigned           LEN_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic             dir,
    input  logic [LEN_W-1:0] len,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    logic             shift_en;
    logic             shift_dir;
    logic             idle;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_shr;
    logic [WIDTH-1:0] q_shl;

    shreg_burst_ctrl #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dir       (dir),
        .len       (len),
        .shift_en  (shift_en),
        .shift_dir (shift_dir),
        .idle      (idle),
        .busy      (busy),
        .done      (done)
    );

    assign q_shr  = {sin_r, q[WIDTH-1:1]};
    assign q_shl  = {q[WIDTH-2:0], sin_l};
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

    // Burst shifts win; manual ops apply only in idle and never on a start cycle
    always_comb begin
        q_next = q;
        if (shift_en) begin
            q_next = (shift_dir == DIR_L) ? q_shl : q_shr;
        end else if (idle && !start && en) begin
            case (mode)
                MODE_HOLD: q_next = q;
                MODE_SHR:  q_next = q_shr;
                MODE_SHL:  q_next = q_shl;
                MODE_LOAD: q_next = d;
                default:   q_next = q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else begin
            q <= q_next;
        end
    end

endmodule
